// File: rtl/addr_resilient_pkg.sv
// Shared types and width helpers for the fault-resilient sliced adder.
// Holds the FSM state encoding and the width rule for the retry counter.
package addr_resilient_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit width able to index v distinct values, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int retry_w(input int max_retry);
    return clog2_min1(max_retry + 1);
  endfunction

endpackage

// File: rtl/addr_slice.sv
// SLICE-bit ripple-carry adder with carry-in and carry-out.
// One instance serves each redundant copy of the sliced adder.
module addr_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_s,
  output logic         o_co
);

  logic [W:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < W; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_co = w_c[W];
  end

endmodule

// File: rtl/addr_nu_resilient.sv
// Dual-copy sliced adder: both copies add one slice per cycle, disagreement
// triggers a bounded number of recomputations before reporting an error.
module addr_nu_resilient
  import addr_resilient_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SLICE     = 4,
  parameter int MAX_RETRY = 2,
  localparam int IW       = clog2_min1(WIDTH),
  localparam int RW       = retry_w(MAX_RETRY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flt_inj,
  input  logic             flt_sticky,
  input  logic [IW-1:0]    flt_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic [RW-1:0]    retries,
  output state_t           dbg_state
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = clog2_min1(NSLICE);

  if (WIDTH < 2) begin : g_bad_width
    $error("addr_nu_resilient: WIDTH must be >= 2");
  end
  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("addr_nu_resilient: WIDTH must be a positive multiple of SLICE");
  end
  if (MAX_RETRY < 0) begin : g_bad_retry
    $error("addr_nu_resilient: MAX_RETRY must be >= 0");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_inj, r_sticky;
  logic [IW-1:0]    r_idx;
  logic [KW-1:0]    r_k;
  logic             r_ca, r_cb;
  logic             r_mis;
  logic [RW-1:0]    r_retry;
  logic [WIDTH-1:0] r_res_a, r_res_b;
  logic [WIDTH:0]   r_sum;
  logic             r_err;

  logic [SLICE-1:0] w_sa, w_sb_a, w_sb_b, w_fmask;
  logic [SLICE-1:0] w_sum_a, w_sum_b, w_sum_b_raw;
  logic             w_co_a, w_co_b;
  logic [WIDTH-1:0] w_full_mask;
  logic [WIDTH-1:0] w_res_a_next, w_res_b_next;
  logic             w_fault_on, w_slice_mis, w_mis_now, w_last;

  // Copy B's fault is live on the first attempt, or on every attempt if sticky.
  assign w_fault_on  = r_inj && ((r_retry == '0) || r_sticky);
  assign w_full_mask = WIDTH'(1) << r_idx;

  always_comb begin
    w_sa    = '0;
    w_sb_a  = '0;
    w_sb_b  = '0;
    w_fmask = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (r_k == KW'(i)) begin
        w_sa    = r_a[i*SLICE +: SLICE];
        w_sb_a  = r_b[i*SLICE +: SLICE];
        w_sb_b  = r_b[i*SLICE +: SLICE];
        w_fmask = w_full_mask[i*SLICE +: SLICE];
      end
    end
  end

  addr_slice #(.W(SLICE)) u_copy_a (
    .i_a (w_sa),
    .i_b (w_sb_a),
    .i_ci(r_ca),
    .o_s (w_sum_a),
    .o_co(w_co_a)
  );

  addr_slice #(.W(SLICE)) u_copy_b (
    .i_a (w_sa),
    .i_b (w_sb_b),
    .i_ci(r_cb),
    .o_s (w_sum_b_raw),
    .o_co(w_co_b)
  );

  assign w_sum_b     = w_sum_b_raw ^ (w_fault_on ? w_fmask : '0);
  assign w_slice_mis = (w_sum_a != w_sum_b) || (w_co_a != w_co_b);
  assign w_mis_now   = r_mis | w_slice_mis;
  assign w_last      = (r_k == KW'(NSLICE - 1));

  always_comb begin
    w_res_a_next = r_res_a;
    w_res_b_next = r_res_b;
    for (int i = 0; i < NSLICE; i++) begin
      if (r_k == KW'(i)) begin
        w_res_a_next[i*SLICE +: SLICE] = w_sum_a;
        w_res_b_next[i*SLICE +: SLICE] = w_sum_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_inj    <= 1'b0;
      r_sticky <= 1'b0;
      r_idx    <= '0;
      r_k      <= '0;
      r_ca     <= 1'b0;
      r_cb     <= 1'b0;
      r_mis    <= 1'b0;
      r_retry  <= '0;
      r_res_a  <= '0;
      r_res_b  <= '0;
      r_sum    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_inj    <= flt_inj;
            r_sticky <= flt_sticky;
            r_idx    <= flt_idx;
            r_k      <= '0;
            r_ca     <= 1'b0;
            r_cb     <= 1'b0;
            r_mis    <= 1'b0;
            r_retry  <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_res_a <= w_res_a_next;
          r_res_b <= w_res_b_next;
          r_ca    <= w_co_a;
          r_cb    <= w_co_b;
          r_mis   <= w_mis_now;
          r_k     <= r_k + KW'(1);
          if (w_last) begin
            if (!w_mis_now) begin
              r_sum   <= {w_co_a, w_res_a_next};
              r_err   <= 1'b0;
              r_state <= S_DONE;
            end else if (int'(r_retry) < MAX_RETRY) begin
              // Start a fresh attempt from slice 0.
              r_retry <= r_retry + RW'(1);
              r_k     <= '0;
              r_ca    <= 1'b0;
              r_cb    <= 1'b0;
              r_mis   <= 1'b0;
            end else begin
              r_sum   <= {w_co_a, w_res_a_next};
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign err       = r_err;
  assign retries   = r_retry;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_addr_nu_resilient.sv
// Directed and randomized bench for the dual-copy sliced adder
// with WIDTH=8, SLICE=4, MAX_RETRY=2.
module tb_addr_nu_resilient;
  import addr_resilient_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       flt_inj, flt_sticky;
  logic [2:0] flt_idx;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
  logic       err;
  logic [1:0] retries;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;

  addr_nu_resilient #(.WIDTH(8), .SLICE(4), .MAX_RETRY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .flt_inj   (flt_inj),
    .flt_sticky(flt_sticky),
    .flt_idx   (flt_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .err       (err),
    .retries   (retries),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       inj;
    logic       st;
    logic [2:0] idx;
    logic [8:0] sum;
    logic       err;
    logic [1:0] ret;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic ti,
                      input logic ts, input logic [2:0] tx);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; flt_inj = ti; flt_sticky = ts; flt_idx = tx;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic seen;
    logic [7:0] ra, rb;
    logic ri, rs;
    logic [2:0] rx;
    int d;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 3'd0, 9'h100, 1'b0, 2'd0, 2};
    vecs[1] = '{8'h3C, 8'h55, 1'b1, 1'b0, 3'd5, 9'h091, 1'b0, 2'd1, 4};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 1'b1, 3'd0, 9'h100, 1'b1, 2'd2, 6};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 9'h000, 1'b0, 2'd0, 2};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 3'd0, 9'h1FE, 1'b0, 2'd0, 2};
    vecs[5] = '{8'h0F, 8'h01, 1'b0, 1'b0, 3'd0, 9'h010, 1'b0, 2'd0, 2};
    vecs[6] = '{8'hA5, 8'h5A, 1'b1, 1'b1, 3'd7, 9'h0FF, 1'b1, 2'd2, 6};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 1'b0, 3'd3, 9'h046, 1'b0, 2'd1, 4};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 1'b1, 3'd2, 9'h080, 1'b0, 2'd0, 2};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; flt_inj = 1'b0; flt_sticky = 1'b0; flt_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_retries", 32'(retries), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].inj, vecs[i].st, vecs[i].idx);
      wait_out(lat);
      @(negedge clk);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("vec%0d_retries", i), 32'(retries), 32'(vecs[i].ret));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      take();
    end

    // backpressure: result held, new operands offered but not accepted
    send(8'h3C, 8'h0F, 1'b0, 1'b0, 3'd0);
    wait_out(lat);
    a = 8'h11; b = 8'h22; flt_inj = 1'b0; flt_sticky = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'h04B);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_after_take_valid", 32'(out_valid), 32'd0);
    check("bp_after_take_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    @(negedge clk);
    check("bp_second_sum", 32'(sum), 32'h033);
    check("bp_second_latency", 32'(lat), 32'd2);
    take();

    // reset during CALC discards the operation
    send(8'h12, 8'h34, 1'b0, 1'b0, 3'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    send(8'h01, 8'h02, 1'b0, 1'b0, 3'd0);
    wait_out(lat);
    @(negedge clk);
    check("midrst_next_sum", 32'(sum), 32'h003);
    check("midrst_next_err", 32'(err), 32'd0);
    take();

    // randomized operands, faults and backpressure
    for (int n = 0; n < 3000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ri = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rx = 3'($urandom_range(0, 7));
      send(ra, rb, ri, rs, rx);
      wait_out(lat);
      d = $urandom_range(0, 3);
      repeat (d) @(posedge clk);
      @(negedge clk);
      check("rnd_sum", 32'(sum), 32'({1'b0, ra} + {1'b0, rb}));
      check("rnd_err", 32'(err), 32'(ri & rs));
      check("rnd_retries", 32'(retries), ri ? (rs ? 32'd2 : 32'd1) : 32'd0);
      take();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
